vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator with pixel-tick divider, x/y counters, syncs and blanking.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output and its counter.
module vga_sync_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_tick_q, frame_tick_d;
    logic             tick;
    logic             line_end;
    logic             frame_end;

    always_comb begin
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        line_end  = tick && (x_q == X_LAST);
        frame_end = line_end && (y_q == Y_LAST);

        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            x_d = line_end ? '0 : x_q + 10'd1;
        end
        if (line_end) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
        end

        // Decoded from next-state x/y so the registered flags land on the same edge as x/y.
        hsync_d      = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d      = !((y_d >= VS_START) && (y_d < VS_END));
        video_on_d   = (x_d < X_VIS) && (y_d < Y_VIS);
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign p_tick     = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Advances on the same edge that raises frame_tick, so the new count is visible during the pulse.
    always_comb begin
        frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a full 640x480 instance for line timing and a tiny-raster instance for frame timing.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic       p_tick_f, hsync_f, vsync_f, video_on_f, frame_tick_f;
    logic [9:0] x_f, y_f;
    logic       p_tick_t, hsync_t, vsync_t, video_on_t, frame_tick_t;
    logic [9:0] x_t, y_t;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_f, fc_t;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut_full (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick_f),
        .x          (x_f),
        .y          (y_f),
        .hsync      (hsync_f),
        .vsync      (vsync_f),
        .video_on   (video_on_f),
        .frame_tick (frame_tick_f)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (fc_f)
`endif
    );

    // Tiny raster: 8 ticks/line (hsync low x=5..6, visible x<4), 7 lines/frame (vsync low y=4..5, visible y<3).
    vga_sync_gen #(
        .TICK_DIV  (2),
        .H_DISPLAY (4),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_DISPLAY (3),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_tiny (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick_t),
        .x          (x_t),
        .y          (y_t),
        .hsync      (hsync_t),
        .vsync      (vsync_t),
        .video_on   (video_on_t),
        .frame_tick (frame_tick_t)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (fc_t)
`endif
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_full(input int tx, input int ty, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (x_f == 10'(tx) && y_f == 10'(ty)) begin
                ok = 1'b1;
                return;
            end
            tick_clk();
        end
    endtask

    task automatic wait_tiny(input int tx, input int ty, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (x_t == 10'(tx) && y_t == 10'(ty)) begin
                ok = 1'b1;
                return;
            end
            tick_clk();
        end
    endtask

    task automatic test_reset();
        logic exp_tick;
        reset = 1'b1;
        repeat (5) tick_clk();
        checks++; if (x_f !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x_f); end
        checks++; if (y_f !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y_f); end
        checks++; if (hsync_f !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync_f); end
        checks++; if (vsync_f !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync_f); end
        checks++; if (video_on_f !== 1'b1) begin errors++; $display("FAIL reset_video_on: got %b expected 1", video_on_f); end
        checks++; if (frame_tick_f !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick_f); end
        checks++; if (p_tick_f !== 1'b0) begin errors++; $display("FAIL reset_p_tick: got %b expected 0", p_tick_f); end
        checks++; if (x_t !== 10'd0 || y_t !== 10'd0) begin errors++; $display("FAIL reset_tiny_xy: got %0d,%0d expected 0,0", x_t, y_t); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (fc_f !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc_f); end
`endif
        $display("reset held 5 clk: x=%0d y=%0d hsync=%b vsync=%b video_on=%b", x_f, y_f, hsync_f, vsync_f, video_on_f);
        reset = 1'b0;
        // div walks 1,2,3 after release, so p_tick shows on the 3rd and 7th edge.
        for (int i = 1; i <= 7; i++) begin
            tick_clk();
            exp_tick = (i == 3 || i == 7);
            checks++;
            if (p_tick_f !== exp_tick) begin
                errors++;
                $display("FAIL p_tick_edge%0d: got %b expected %b", i, p_tick_f, exp_tick);
            end
        end
        checks++; if (x_f !== 10'd1) begin errors++; $display("FAIL x_after_first_tick: got %0d expected 1", x_f); end
        $display("post-release p_tick pattern done: x=%0d", x_f);
    endtask

    task automatic test_horizontal();
        bit ok;
        int hold;
        int low;
        wait_full(639, 0, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_x639: got timeout expected x=639"); end
        checks++; if (video_on_f !== 1'b1) begin errors++; $display("FAIL video_on_x639: got %b expected 1", video_on_f); end
        wait_full(640, 0, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_x640: got timeout expected x=640"); end
        checks++; if (video_on_f !== 1'b0) begin errors++; $display("FAIL video_on_x640: got %b expected 0", video_on_f); end
        hold = 0;
        while (x_f == 10'd640 && hold < 10) begin
            hold++;
            tick_clk();
        end
        checks++; if (hold != 4) begin errors++; $display("FAIL x_hold_clks: got %0d expected 4", hold); end
        wait_full(655, 0, 100, ok);
        checks++; if (!ok || hsync_f !== 1'b1) begin errors++; $display("FAIL hsync_x655: got %b expected 1", hsync_f); end
        wait_full(656, 0, 8, ok);
        checks++; if (!ok || hsync_f !== 1'b0) begin errors++; $display("FAIL hsync_x656: got %b expected 0", hsync_f); end
        low = 0;
        while (hsync_f == 1'b0 && low < 1000) begin
            low++;
            tick_clk();
        end
        checks++; if (low != 384) begin errors++; $display("FAIL hsync_low_clks: got %0d expected 384", low); end
        checks++; if (x_f !== 10'd752) begin errors++; $display("FAIL hsync_rise_x: got %0d expected 752", x_f); end
        $display("hsync low for %0d clk, rose at x=%0d", low, x_f);
        wait_full(799, 0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_x799: got timeout expected x=799"); end
        wait_full(0, 1, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL line_wrap: got x=%0d y=%0d expected 0,1", x_f, y_f); end
        checks++; if (video_on_f !== 1'b1 || hsync_f !== 1'b1) begin errors++; $display("FAIL line_start_flags: got video_on=%b hsync=%b expected 1,1", video_on_f, hsync_f); end
        checks++; if (frame_tick_f !== 1'b0) begin errors++; $display("FAIL line_wrap_frame_tick: got %b expected 0", frame_tick_f); end
        $display("line wrap: x=%0d y=%0d", x_f, y_f);
    endtask

    task automatic test_reset_mid_full();
        bit ok;
        wait_full(700, 1, 4000, ok);
        checks++; if (!ok || hsync_f !== 1'b0) begin errors++; $display("FAIL mid_full_pre_hsync: got %b expected 0", hsync_f); end
        reset = 1'b1;
        tick_clk();
        checks++; if (x_f !== 10'd0 || y_f !== 10'd0) begin errors++; $display("FAIL mid_full_xy: got %0d,%0d expected 0,0", x_f, y_f); end
        checks++; if (hsync_f !== 1'b1 || vsync_f !== 1'b1) begin errors++; $display("FAIL mid_full_sync: got %b%b expected 11", hsync_f, vsync_f); end
        checks++; if (frame_tick_f !== 1'b0 || p_tick_f !== 1'b0) begin errors++; $display("FAIL mid_full_ticks: got %b%b expected 00", frame_tick_f, p_tick_f); end
        reset = 1'b0;
        $display("mid-line reset at x=700: x=%0d hsync=%b", x_f, hsync_f);
    endtask

    task automatic test_frame_cnt_wrap();
`ifdef VGA_FRAME_CNT_EN
        int n;
        logic [7:0] first_val;
        checks++; if (fc_t !== 8'd0) begin errors++; $display("FAIL frame_cnt_start: got %0d expected 0", fc_t); end
        n = 0;
        first_val = 8'hxx;
        for (int i = 0; i < 256 * 112 + 400 && n < 256; i++) begin
            tick_clk();
            if (frame_tick_t === 1'b1) begin
                n++;
                if (n == 1) first_val = fc_t;
            end
        end
        checks++; if (first_val !== 8'd1) begin errors++; $display("FAIL frame_cnt_first: got %0d expected 1", first_val); end
        checks++; if (n != 256) begin errors++; $display("FAIL frame_cnt_ticks: got %0d expected 256", n); end
        checks++; if (fc_t !== 8'd0) begin errors++; $display("FAIL frame_cnt_wrap: got %0d expected 0", fc_t); end
        $display("256 frames: frame_cnt=%0d", fc_t);
`endif
    endtask

    task automatic test_vertical();
        bit ok;
        int vs_low, vo_high, ft_cnt, mism;
        logic eh, ev, evo;
        wait_tiny(1, 0, 300, ok);
        wait_tiny(0, 0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_tiny_frame_start: got timeout expected 0,0"); end
        vs_low = 0; vo_high = 0; ft_cnt = 0; mism = 0;
        for (int i = 0; i < 112; i++) begin
            eh  = !(x_t >= 10'd5 && x_t <= 10'd6);
            ev  = !(y_t >= 10'd4 && y_t <= 10'd5);
            evo = (x_t < 10'd4) && (y_t < 10'd3);
            if (hsync_t !== eh || vsync_t !== ev || video_on_t !== evo) mism++;
            if (vsync_t === 1'b0) vs_low++;
            if (video_on_t === 1'b1) vo_high++;
            if (frame_tick_t === 1'b1) ft_cnt++;
            tick_clk();
        end
        checks++; if (mism != 0) begin errors++; $display("FAIL tiny_flag_decode: got %0d bad clks expected 0", mism); end
        checks++; if (vs_low != 32) begin errors++; $display("FAIL vsync_low_clks: got %0d expected 32", vs_low); end
        checks++; if (vo_high != 24) begin errors++; $display("FAIL video_on_clks: got %0d expected 24", vo_high); end
        checks++; if (ft_cnt != 1) begin errors++; $display("FAIL frame_tick_per_frame: got %0d expected 1", ft_cnt); end
        $display("tiny frame scan: vsync_low=%0d video_on=%0d frame_ticks=%0d", vs_low, vo_high, ft_cnt);
    endtask

    task automatic test_frame_wrap();
        bit ok;
        int n, per;
`ifdef VGA_FRAME_CNT_EN
        logic [7:0] cnt0;
`endif
        wait_tiny(7, 6, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_tiny_last: got timeout expected 7,6"); end
        checks++; if (frame_tick_t !== 1'b0 || video_on_t !== 1'b0) begin errors++; $display("FAIL pre_wrap_flags: got ft=%b vo=%b expected 0,0", frame_tick_t, video_on_t); end
`ifdef VGA_FRAME_CNT_EN
        cnt0 = fc_t;
`endif
        n = 0;
        while (x_t == 10'd7 && n < 5) begin
            n++;
            tick_clk();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL last_pixel_hold: got %0d expected 2", n); end
        checks++; if (x_t !== 10'd0 || y_t !== 10'd0) begin errors++; $display("FAIL frame_wrap_xy: got %0d,%0d expected 0,0", x_t, y_t); end
        checks++; if (frame_tick_t !== 1'b1) begin errors++; $display("FAIL frame_tick_high: got %b expected 1", frame_tick_t); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (fc_t !== 8'(cnt0 + 8'd1)) begin errors++; $display("FAIL frame_cnt_inc: got %0d expected %0d", fc_t, 8'(cnt0 + 8'd1)); end
`endif
        tick_clk();
        checks++; if (frame_tick_t !== 1'b0) begin errors++; $display("FAIL frame_tick_width: got %b expected 0", frame_tick_t); end
        per = 1;
        while (frame_tick_t !== 1'b1 && per < 300) begin
            tick_clk();
            per++;
        end
        checks++; if (per != 112) begin errors++; $display("FAIL frame_period: got %0d expected 112", per); end
        $display("frame wrap: period=%0d clk", per);
    endtask

    task automatic test_reset_mid_tiny();
        bit ok;
        wait_tiny(5, 5, 300, ok);
        checks++; if (!ok || hsync_t !== 1'b0 || vsync_t !== 1'b0) begin errors++; $display("FAIL mid_tiny_pre_sync: got %b%b expected 00", hsync_t, vsync_t); end
        reset = 1'b1;
        tick_clk();
        checks++; if (x_t !== 10'd0 || y_t !== 10'd0) begin errors++; $display("FAIL mid_tiny_xy: got %0d,%0d expected 0,0", x_t, y_t); end
        checks++; if (hsync_t !== 1'b1 || vsync_t !== 1'b1 || video_on_t !== 1'b1) begin errors++; $display("FAIL mid_tiny_flags: got %b%b%b expected 111", hsync_t, vsync_t, video_on_t); end
        checks++; if (frame_tick_t !== 1'b0) begin errors++; $display("FAIL mid_tiny_frame_tick: got %b expected 0", frame_tick_t); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (fc_t !== 8'd0) begin errors++; $display("FAIL mid_tiny_frame_cnt: got %0d expected 0", fc_t); end
`endif
        reset = 1'b0;
        tick_clk();
        checks++; if (hsync_t !== 1'b1 || vsync_t !== 1'b1) begin errors++; $display("FAIL post_reset_sync: got %b%b expected 11", hsync_t, vsync_t); end
        $display("mid-frame reset at 5,5: x=%0d y=%0d hsync=%b vsync=%b", x_t, y_t, hsync_t, vsync_t);
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_reset_mid_full();
        test_frame_cnt_wrap();
        test_vertical();
        test_frame_wrap();
        test_reset_mid_tiny();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
